ro_freq_meter: RTL and testbench

Multi-channel ring-oscillator frequency meter, the parametrised successor to the single-counter temperature-sensor readout. It selects one of N_CH oscillator inputs, counts its rising edges over a programmable window of system clocks and averages 2^sum_sel windows. It presents the result on a valid/ready handshake to the serial or parallel readout logic in the top. It supports one-shot and continuous measurement, per-window saturation and an overflow flag.

---
 rtl/ro_meter_pkg.sv | 13 +
 rtl/ro_freq_meter_if.sv | 29 ++
 rtl/ro_edge_sync.sv | 24 ++
 rtl/ro_freq_meter.sv | 184 ++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCount,
    StDone
  } state_e;

  localparam int unsigned SETTLE_CYC = 3;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Result handshake between the meter and the readout logic.
interface ro_freq_meter_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CH_W  = 2
) ();

  logic [CNT_W-1:0] result;
  logic [CH_W-1:0]  result_ch;
  logic             overflow;
  logic             valid;
  logic             ready;

  modport master (
    output result,
    output result_ch,
    output overflow,
    output valid,
    input  ready
  );

  modport slave (
    input  result,
    input  result_ch,
    input  overflow,
    input  valid,
    output ready
  );

endinterface

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for one oscillator input.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], ro_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts edges over W-cycle windows
// and averages 2^s consecutive windows.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WIN_W   = 12,
  parameter int unsigned MAX_SUM = 7,
  localparam int unsigned CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic [N_CH-1:0]   ro_in_i,
  input  logic [CH_W-1:0]   ch_sel_i,
  input  logic [2:0]        sum_sel_i,
  input  logic [WIN_W-1:0]  win_len_i,
  input  logic              start_i,
  input  logic              cont_i,
  output logic              busy_o,
  ro_freq_meter_if.master   res_if
);

  localparam int unsigned ACC_W = CNT_W + MAX_SUM;
  localparam int unsigned NW_W  = MAX_SUM + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0] pulses;

  for (genvar c = 0; c < N_CH; c++) begin : g_sync
    ro_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .ro_i    (ro_in_i[c]),
      .pulse_o (pulses[c])
    );
  end

  state_e            state_q, state_d;
  logic [1:0]        settle_q, settle_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [2:0]        s_q, s_d;
  logic [WIN_W-1:0]  w_q, w_d;
  logic [WIN_W-1:0]  wcyc_q, wcyc_d;
  logic [NW_W-1:0]   nwin_q, nwin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  res_q, res_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic              res_ovf_q, res_ovf_d;

  logic              pulse, sat, win_end, last_win, do_latch;
  logic [CNT_W-1:0]  win_cnt;
  logic [ACC_W-1:0]  acc_sum;
  logic [NW_W-1:0]   nwin_last;
  logic [2:0]        s_clamp;
  logic [WIN_W-1:0]  w_new;

  assign pulse     = pulses[ch_q];
  assign sat       = pulse && (cnt_q == CNT_MAX);
  assign win_cnt   = (pulse && !sat) ? cnt_q + CNT_W'(1) : cnt_q;
  assign win_end   = (wcyc_q == w_q - WIN_W'(1));
  assign nwin_last = (NW_W'(1) << s_q) - NW_W'(1);
  assign last_win  = (nwin_q == nwin_last);
  // The window's final pulse is folded in on the same cycle it closes.
  assign acc_sum   = acc_q + ACC_W'(win_cnt);
  assign s_clamp   = (32'(sum_sel_i) > MAX_SUM) ? 3'(MAX_SUM) : sum_sel_i;
  assign w_new     = (win_len_i == '0) ? WIN_W'(1) : win_len_i;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ch_d      = ch_q;
    s_d       = s_q;
    w_d       = w_q;
    wcyc_d    = wcyc_q;
    nwin_d    = nwin_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ch_d  = res_ch_q;
    res_ovf_d = res_ovf_q;
    do_latch  = 1'b0;

    if (!ena_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            do_latch = 1'b1;
            state_d  = StSettle;
          end
        end
        StSettle: begin
          settle_d = settle_q + 2'd1;
          if (settle_q == 2'(SETTLE_CYC - 1)) state_d = StCount;
        end
        StCount: begin
          cnt_d  = win_cnt;
          wcyc_d = wcyc_q + WIN_W'(1);
          if (sat) ovf_d = 1'b1;
          if (win_end) begin
            wcyc_d = '0;
            cnt_d  = '0;
            acc_d  = acc_sum;
            nwin_d = nwin_q + NW_W'(1);
            if (last_win) begin
              state_d   = StDone;
              res_d     = CNT_W'(acc_sum >> s_q);
              res_ch_d  = ch_q;
              res_ovf_d = ovf_q | sat;
            end
          end
        end
        StDone: begin
          if (res_if.ready) begin
            if (cont_i) begin
              do_latch = 1'b1;
              state_d  = StSettle;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (do_latch) begin
      ch_d     = ch_sel_i;
      s_d      = s_clamp;
      w_d      = w_new;
      settle_d = '0;
      wcyc_d   = '0;
      nwin_d   = '0;
      cnt_d    = '0;
      acc_d    = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      ch_q      <= '0;
      s_q       <= '0;
      w_q       <= WIN_W'(1);
      wcyc_q    <= '0;
      nwin_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ch_q  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      ch_q      <= ch_d;
      s_q       <= s_d;
      w_q       <= w_d;
      wcyc_q    <= wcyc_d;
      nwin_q    <= nwin_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ch_q  <= res_ch_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign res_if.valid     = (state_q == StDone);
  assign res_if.result    = res_q;
  assign res_if.result_ch = res_ch_q;
  assign res_if.overflow  = res_ovf_q;
  assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed plus randomized bench for ro_freq_meter; a 16-bit/7-sum instance and an
// 8-bit/4-sum instance share the oscillator sources.
module tb_ro_freq_meter;

  localparam int TMO = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Oscillator sources: per[c] is the full period in clk cycles (even), 0 = static low.
  logic [3:0] ro = '0;
  int per[4] = '{4, 10, 20, 0};
  int ph[4]  = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (per[c] >= 2) begin
        ph[c]++;
        if (ph[c] >= per[c] / 2) begin
          ph[c] = 0;
          ro[c] = ~ro[c];
        end
      end
    end
  end

  logic        ena_a = 1'b1, st_a = 1'b0, cont_a = 1'b0, rdy_a = 1'b0;
  logic [1:0]  ch_a = '0;
  logic [2:0]  sum_a = '0;
  logic [11:0] win_a = '0;
  logic        busy_a;

  logic        ena_b = 1'b1, st_b = 1'b0, cont_b = 1'b0, rdy_b = 1'b0;
  logic        ch_b = 1'b0;
  logic [2:0]  sum_b = '0;
  logic [11:0] win_b = '0;
  logic        busy_b;

  ro_freq_meter_if #(.CNT_W(16), .CH_W(2)) if_a ();
  ro_freq_meter_if #(.CNT_W(8),  .CH_W(1)) if_b ();
  assign if_a.ready = rdy_a;
  assign if_b.ready = rdy_b;

  ro_freq_meter #(.N_CH(4), .CNT_W(16), .WIN_W(12), .MAX_SUM(7)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_i     (ena_a),
    .ro_in_i   (ro),
    .ch_sel_i  (ch_a),
    .sum_sel_i (sum_a),
    .win_len_i (win_a),
    .start_i   (st_a),
    .cont_i    (cont_a),
    .busy_o    (busy_a),
    .res_if    (if_a)
  );

  ro_freq_meter #(.N_CH(2), .CNT_W(8), .WIN_W(12), .MAX_SUM(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_i     (ena_b),
    .ro_in_i   (ro[1:0]),
    .ch_sel_i  (ch_b),
    .sum_sel_i (sum_b),
    .win_len_i (win_b),
    .start_i   (st_b),
    .cont_i    (cont_b),
    .busy_o    (busy_b),
    .res_if    (if_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_m(input bit b, input int ch, input int s, input int w);
    @(negedge clk);
    if (b) begin
      ch_b = 1'(ch); sum_b = 3'(s); win_b = 12'(w); st_b = 1'b1;
    end else begin
      ch_a = 2'(ch); sum_a = 3'(s); win_a = 12'(w); st_a = 1'b1;
    end
    @(posedge clk);
    #1;
    st_a = 1'b0;
    st_b = 1'b0;
  endtask

  // Counts clock edges until valid is seen; returns TMO+ on expiry.
  task automatic wait_valid(input bit b, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(b ? if_b.valid : if_a.valid) && n < TMO);
  endtask

  task automatic hs(input bit b);
    @(negedge clk);
    if (b) rdy_b = 1'b1;
    else   rdy_a = 1'b1;
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  // Reference: pulses are strictly periodic and W is a multiple of the period, so
  // every window holds exactly W/P edges; averaging identical windows returns it.
  function automatic longint exp_res(input int w, input int p, input int cnt_w);
    longint m = (longint'(1) << cnt_w) - 1;
    return (w / p > m) ? m : longint'(w / p);
  endfunction

  function automatic int exp_lat(input int w, input int s, input int max_sum);
    int weff = (w == 0) ? 1 : w;
    int seff = (s > max_sum) ? max_sum : s;
    return 3 + weff * (1 << seff);
  endfunction

  initial begin
    int n, ch, s, w, p;
    int pset[6] = '{4, 6, 8, 10, 12, 20};

    // Reset state
    #2;
    chk("rst_valid_a", 64'(if_a.valid), 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_result_a", 64'(if_a.result), 64'd0);
    chk("rst_ch_a", 64'(if_a.result_ch), 64'd0);
    chk("rst_ovf_a", 64'(if_a.overflow), 64'd0);
    chk("rst_valid_b", 64'(if_b.valid), 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);

    // Channel 1 period 10, W=100, s=0
    start_m(0, 1, 0, 100);
    chk("busy_after_start", 64'(busy_a), 64'd1);
    wait_valid(0, n);
    chk("t1_lat", 64'(n), 64'(exp_lat(100, 0, 7)));
    chk("t1_result", 64'(if_a.result), 64'd10);
    chk("t1_ovf", 64'(if_a.overflow), 64'd0);
    chk("t1_ch", 64'(if_a.result_ch), 64'd1);
    hs(0);
    chk("t1_idle_busy", 64'(busy_a), 64'd0);
    chk("t1_idle_valid", 64'(if_a.valid), 64'd0);

    // Same with four windows averaged
    start_m(0, 1, 2, 100);
    wait_valid(0, n);
    chk("t2_lat", 64'(n), 64'd403);
    chk("t2_result", 64'(if_a.result), 64'd10);
    hs(0);

    // Randomized channels, periods, windows; inputs scrambled mid-measurement
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 3; c++) per[c] = pset[$urandom_range(0, 5)];
      per[3] = pset[$urandom_range(0, 5)];
      repeat (50) @(posedge clk);
      ch = $urandom_range(0, 3);
      p  = per[ch];
      w  = p * $urandom_range(2, 10);
      s  = $urandom_range(0, 3);
      start_m(0, ch, s, w);
      ch_a  = 2'($urandom);
      sum_a = 3'($urandom);
      win_a = 12'($urandom);
      wait_valid(0, n);
      chk("rnd_lat", 64'(n), 64'(exp_lat(w, s, 7)));
      chk("rnd_result", 64'(if_a.result), 64'(exp_res(w, p, 16)));
      chk("rnd_ovf", 64'(if_a.overflow), 64'd0);
      chk("rnd_ch", 64'(if_a.result_ch), 64'(ch));
      hs(0);
    end

    per[0] = 4; per[1] = 10; per[2] = 20; per[3] = 0;
    repeat (50) @(posedge clk);

    // Continuous mode: hold, handshake, then back-to-back throughput
    cont_a = 1'b1;
    start_m(0, 1, 1, 50);
    wait_valid(0, n);
    chk("cont_lat", 64'(n), 64'd103);
    chk("cont_result", 64'(if_a.result), 64'd5);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      chk("cont_hold_result", 64'(if_a.result), 64'd5);
    end
    chk("cont_hold_valid", 64'(if_a.valid), 64'd1);
    hs(0);
    chk("cont_drop_valid", 64'(if_a.valid), 64'd0);
    chk("cont_resettle_busy", 64'(busy_a), 64'd1);
    wait_valid(0, n);
    chk("cont_relat", 64'(n), 64'd103);
    chk("cont_result2", 64'(if_a.result), 64'd5);
    rdy_a = 1'b1;
    wait_valid(0, n);
    chk("cont_period", 64'(n), 64'd104);
    chk("cont_result3", 64'(if_a.result), 64'd5);
    cont_a = 1'b0;
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    chk("cont_end_busy", 64'(busy_a), 64'd0);

    // Abort mid-COUNT via ena
    start_m(0, 2, 0, 100);
    repeat (20) @(posedge clk);
    #1;
    ena_a = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_valid", 64'(if_a.valid), 64'd0);
    chk("abort_keep_result", 64'(if_a.result), 64'd5);
    ena_a = 1'b1;

    // Asynchronous reset mid-COUNT
    start_m(0, 2, 0, 100);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_valid", 64'(if_a.valid), 64'd0);
    chk("arst_result", 64'(if_a.result), 64'd0);
    chk("arst_ch", 64'(if_a.result_ch), 64'd0);
    chk("arst_ovf", 64'(if_a.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // win_len=0 -> W=1, 128 windows; at most 13 edges in 128 cycles, so average 0
    start_m(0, 1, 7, 0);
    wait_valid(0, n);
    chk("w0_lat", 64'(n), 64'(exp_lat(0, 7, 7)));
    chk("w0_result", 64'(if_a.result), 64'd0);
    chk("w0_ch", 64'(if_a.result_ch), 64'd1);
    hs(0);

    // 8-bit instance: period-2 source saturates every window
    per[0] = 2;
    repeat (20) @(posedge clk);
    start_m(1, 0, 1, 1000);
    wait_valid(1, n);
    chk("sat_lat", 64'(n), 64'(exp_lat(1000, 1, 4)));
    chk("sat_result", 64'(if_b.result), 64'(exp_res(1000, 2, 8)));
    chk("sat_ovf", 64'(if_b.overflow), 64'd1);
    chk("sat_ch", 64'(if_b.result_ch), 64'd0);
    hs(1);

    // sum_sel beyond MAX_SUM=4 clamps; 16 one-cycle windows see 8 edges, 8>>4 = 0
    start_m(1, 0, 5, 0);
    wait_valid(1, n);
    chk("clamp_lat", 64'(n), 64'(exp_lat(0, 5, 4)));
    chk("clamp_result", 64'(if_b.result), 64'd0);
    chk("clamp_ovf", 64'(if_b.overflow), 64'd0);
    hs(1);
    start_m(1, 0, 3, 0);
    wait_valid(1, n);
    chk("noclamp_lat", 64'(n), 64'(exp_lat(0, 3, 4)));
    hs(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
